// File: rtl/hazard_scoreboard_if.sv
// ID-stage operand/hazard bundle between the decode stage and the hazard scoreboard.
// The master drives the decode-side fields; the slave returns stall and operand data.
interface hazard_scoreboard_if #(
    parameter int DATA_W = 32
);
    logic              id_valid;
    logic [4:0]        id_dest;
    logic              id_we;
    logic              id_is_load;
    logic [4:0]        src1_addr;
    logic [4:0]        src2_addr;
    logic              src1_re;
    logic              src2_re;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic              stall;
    logic [DATA_W-1:0] src1_data;
    logic [DATA_W-1:0] src2_data;
    logic              fwd1_hit;
    logic              fwd2_hit;

    modport master (
        output id_valid, id_dest, id_we, id_is_load,
        output src1_addr, src2_addr, src1_re, src2_re, rf_rdata1, rf_rdata2,
        input  stall, src1_data, src2_data, fwd1_hit, fwd2_hit
    );

    modport slave (
        input  id_valid, id_dest, id_we, id_is_load,
        input  src1_addr, src2_addr, src1_re, src2_re, rf_rdata1, rf_rdata2,
        output stall, src1_data, src2_data, fwd1_hit, fwd2_hit
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks destination registers of in-flight instructions after ID, forwards
// the youngest matching stage result and stalls on load-use hazards.
module hazard_scoreboard #(
    parameter int NUM_STAGES = 3,
    parameter int DATA_W     = 32,
    parameter int LOAD_LAT   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pipe_go,
    input  logic                         flush,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_data,
    output logic [$clog2(NUM_STAGES+1)-1:0] inflight,
    hazard_scoreboard_if.slave           id_if
);
    localparam int CNT_W = $clog2(NUM_STAGES + 1);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic [NUM_STAGES-1:0] valid_q, valid_d;
    logic [NUM_STAGES-1:0] we_q, we_d;
    logic [NUM_STAGES-1:0] load_q, load_d;
    logic [4:0]            dest_q [NUM_STAGES];
    logic [4:0]            dest_d [NUM_STAGES];
    logic [CNT_W-1:0]      inflight_q, inflight_d;

    logic             hit1, hit2;
    logic [IDX_W-1:0] win1, win2;
    logic             stall_t1, stall_t2;

    function automatic logic entry_match(input int unsigned i, input logic [4:0] addr,
                                         input logic re);
        return valid_q[i] && we_q[i] && re && (dest_q[i] == addr) && (addr != 5'd0);
    endfunction

    // Walk oldest to youngest so the lowest matching index is the last one written.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        win1 = '0;
        win2 = '0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (entry_match(NUM_STAGES - 1 - k, id_if.src1_addr, id_if.src1_re)) begin
                hit1 = 1'b1;
                win1 = IDX_W'(NUM_STAGES - 1 - k);
            end
            if (entry_match(NUM_STAGES - 1 - k, id_if.src2_addr, id_if.src2_re)) begin
                hit2 = 1'b1;
                win2 = IDX_W'(NUM_STAGES - 1 - k);
            end
        end
        hit1 = hit1 & ~reset;
        hit2 = hit2 & ~reset;
        stall_t1 = hit1 && load_q[win1] && (32'(win1) < LOAD_LAT);
        stall_t2 = hit2 && load_q[win2] && (32'(win2) < LOAD_LAT);
    end

    always_comb begin
        id_if.stall     = (stall_t1 | stall_t2) & id_if.id_valid & ~flush & ~reset;
        id_if.fwd1_hit  = hit1;
        id_if.fwd2_hit  = hit2;
        id_if.src1_data = hit1 ? stage_data[win1*DATA_W +: DATA_W] : id_if.rf_rdata1;
        id_if.src2_data = hit2 ? stage_data[win2*DATA_W +: DATA_W] : id_if.rf_rdata2;
    end

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        load_d  = load_q;
        for (int unsigned i = 0; i < NUM_STAGES; i++) dest_d[i] = dest_q[i];

        if (pipe_go) begin
            for (int unsigned i = 1; i < NUM_STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                we_d[i]    = we_q[i-1];
                load_d[i]  = load_q[i-1];
                dest_d[i]  = dest_q[i-1];
            end
            valid_d[0] = id_if.id_valid & ~id_if.stall & ~flush;
            we_d[0]    = id_if.id_we;
            load_d[0]  = id_if.id_is_load;
            dest_d[0]  = id_if.id_dest;
        end else if (flush) begin
            valid_d[0] = 1'b0;
        end

        if (reset) valid_d = '0;

        inflight_d = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++)
            inflight_d = inflight_d + CNT_W'(valid_d[i]);
    end

    always_ff @(posedge clk) begin
        valid_q    <= valid_d;
        we_q       <= we_d;
        load_q     <= load_d;
        dest_q     <= dest_d;
        inflight_q <= inflight_d;
    end

    assign inflight = inflight_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of forwarding priority, load-use stall, flush and reset
// behaviour of hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;
    localparam int NS = 3;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          pipe_go;
    logic          flush;
    logic [NS*DW-1:0] stage_data;
    logic [1:0]    inflight;

    int n_vec = 0;
    int n_err = 0;

    hazard_scoreboard_if #(.DATA_W(DW)) bus ();

    hazard_scoreboard #(.NUM_STAGES(NS), .DATA_W(DW), .LOAD_LAT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_go    (pipe_go),
        .flush      (flush),
        .stage_data (stage_data),
        .inflight   (inflight),
        .id_if      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_go        = 1'b0;
        flush          = 1'b0;
        bus.id_valid   = 1'b0;
        bus.id_dest    = 5'd0;
        bus.id_we      = 1'b0;
        bus.id_is_load = 1'b0;
        bus.src1_addr  = 5'd0;
        bus.src2_addr  = 5'd0;
        bus.src1_re    = 1'b0;
        bus.src2_re    = 1'b0;
        bus.rf_rdata1  = 32'h0;
        bus.rf_rdata2  = 32'h0;
        stage_data     = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [4:0] dest, input logic we, input logic ld);
        bus.id_valid   = 1'b1;
        bus.id_dest    = dest;
        bus.id_we      = we;
        bus.id_is_load = ld;
        bus.src1_re    = 1'b0;
        bus.src2_re    = 1'b0;
        pipe_go        = 1'b1;
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle();

        // reset state and combinational behaviour during reset
        bus.id_valid  = 1'b1;
        bus.src1_addr = 5'd5;
        bus.src1_re   = 1'b1;
        bus.rf_rdata1 = 32'h55;
        #1;
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_src1", bus.src1_data, 32'h55);
        step();
        check("rst_inflight", {30'd0, inflight}, 32'd0);
        check("rst_fwd1", {31'd0, bus.fwd1_hit}, 32'd0);
        reset = 1'b0;

        // ALU back-to-back
        do_reset();
        issue(5'd5, 1'b1, 1'b0);
        bus.id_dest    = 5'd9;
        bus.id_we      = 1'b0;
        bus.src1_addr  = 5'd5;
        bus.src1_re    = 1'b1;
        bus.rf_rdata1  = 32'hDEAD;
        stage_data     = {32'h0, 32'h0, 32'h11};
        #1;
        check("alu_fwd1", {31'd0, bus.fwd1_hit}, 32'd1);
        check("alu_src1", bus.src1_data, 32'h11);
        check("alu_stall", {31'd0, bus.stall}, 32'd0);
        check("alu_inflight", {30'd0, inflight}, 32'd1);

        // load-use stall
        do_reset();
        issue(5'd7, 1'b1, 1'b1);
        bus.id_dest    = 5'd8;
        bus.id_we      = 1'b1;
        bus.id_is_load = 1'b0;
        bus.src2_addr  = 5'd7;
        bus.src2_re    = 1'b1;
        bus.rf_rdata2  = 32'h22;
        stage_data     = {32'hC3, 32'hB2, 32'hA1};
        #1;
        check("lu_stall", {31'd0, bus.stall}, 32'd1);
        check("lu_fwd2", {31'd0, bus.fwd2_hit}, 32'd1);
        step();
        check("lu_stall_gone", {31'd0, bus.stall}, 32'd0);
        check("lu_src2_mem", bus.src2_data, 32'hB2);
        check("lu_bubble_inflight", {30'd0, inflight}, 32'd1);
        step();
        check("lu_after_inflight", {30'd0, inflight}, 32'd2);
        check("lu_src2_wb", bus.src2_data, 32'hC3);

        // youngest-first priority, hold, reset mid-operation
        do_reset();
        issue(5'd3, 1'b1, 1'b0);
        issue(5'd4, 1'b1, 1'b0);
        issue(5'd3, 1'b1, 1'b0);
        pipe_go       = 1'b0;
        bus.id_valid  = 1'b0;
        bus.src1_addr = 5'd3;
        bus.src1_re   = 1'b1;
        bus.src2_addr = 5'd4;
        bus.src2_re   = 1'b1;
        bus.rf_rdata1 = 32'h77;
        stage_data    = {32'hC, 32'hB, 32'hA};
        #1;
        check("pri_src1", bus.src1_data, 32'hA);
        check("pri_fwd1", {31'd0, bus.fwd1_hit}, 32'd1);
        check("pri_src2", bus.src2_data, 32'hB);
        check("pri_inflight", {30'd0, inflight}, 32'd3);
        step();
        check("hold_inflight", {30'd0, inflight}, 32'd3);
        check("hold_src1", bus.src1_data, 32'hA);
        bus.src1_re = 1'b0;
        #1;
        check("nore_fwd1", {31'd0, bus.fwd1_hit}, 32'd0);
        check("nore_src1", bus.src1_data, 32'h77);
        bus.src1_re  = 1'b1;
        bus.id_valid = 1'b1;
        pipe_go      = 1'b1;
        reset        = 1'b1;
        #1;
        check("midrst_stall", {31'd0, bus.stall}, 32'd0);
        check("midrst_fwd1", {31'd0, bus.fwd1_hit}, 32'd0);
        check("midrst_src1", bus.src1_data, 32'h77);
        step();
        reset   = 1'b0;
        pipe_go = 1'b0;
        #1;
        check("midrst_inflight", {30'd0, inflight}, 32'd0);
        check("midrst_fwd1_after", {31'd0, bus.fwd1_hit}, 32'd0);
        check("midrst_fwd2_after", {31'd0, bus.fwd2_hit}, 32'd0);

        // r0 never matches
        do_reset();
        issue(5'd0, 1'b1, 1'b0);
        pipe_go       = 1'b0;
        bus.id_valid  = 1'b0;
        bus.src1_addr = 5'd0;
        bus.src1_re   = 1'b1;
        bus.rf_rdata1 = 32'h0;
        stage_data    = {32'h0, 32'h0, 32'h99};
        #1;
        check("r0_fwd1", {31'd0, bus.fwd1_hit}, 32'd0);
        check("r0_src1", bus.src1_data, 32'h0);
        check("r0_inflight", {30'd0, inflight}, 32'd1);

        // flush during load-use stall
        do_reset();
        issue(5'd1, 1'b1, 1'b0);
        issue(5'd7, 1'b1, 1'b1);
        pipe_go        = 1'b0;
        bus.id_dest    = 5'd9;
        bus.id_is_load = 1'b0;
        bus.src1_addr  = 5'd1;
        bus.src1_re    = 1'b1;
        bus.src2_addr  = 5'd7;
        bus.src2_re    = 1'b1;
        bus.rf_rdata2  = 32'h22;
        stage_data     = {32'hC, 32'hB, 32'hA};
        #1;
        check("fl_pre_stall", {31'd0, bus.stall}, 32'd1);
        flush = 1'b1;
        #1;
        check("fl_stall", {31'd0, bus.stall}, 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("fl_inflight", {30'd0, inflight}, 32'd1);
        check("fl_fwd2", {31'd0, bus.fwd2_hit}, 32'd0);
        check("fl_src2", bus.src2_data, 32'h22);
        check("fl_stall_after", {31'd0, bus.stall}, 32'd0);
        check("fl_src1_held", bus.src1_data, 32'hB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 3, meaning the number of tracked stages after ID (index 0 = EXE, 1 = MEM, 2 = WB).
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the register data width.
REQ-003 The block SHALL have parameter LOAD_LAT, default 1, meaning a load result is valid only at stage index >= LOAD_LAT (1..NUM_STAGES-1).
REQ-004 The block SHALL have ports clk (in, 1, clock) and reset (in, 1, reset; synchronous, active-high).
REQ-005 The block SHALL have pipe_go (in, 1): the pipeline advances this cycle.
REQ-006 The block SHALL have flush (in, 1): kill the ID instruction and the stage-0 entry.
REQ-007 The block SHALL have id_valid (in, 1), id_dest (in, 5), id_we (in, 1) and id_is_load (in, 1), describing the instruction in ID.
REQ-008 The block SHALL have src1_addr/src2_addr (in, 5 each), src1_re/src2_re (in, 1 each) and rf_rdata1/rf_rdata2 (in, DATA_W each): ID source operands.
REQ-009 The block SHALL have stage_data (in, NUM_STAGES*DATA_W): result of stage i at bits [i*DATA_W +: DATA_W].
REQ-010 The block SHALL have stall (out, 1), src1_data/src2_data (out, DATA_W each), fwd1_hit/fwd2_hit (out, 1 each) and inflight (out, clog2(NUM_STAGES+1)).

Function
REQ-011 Per stage i the block SHALL hold valid_i, dest_i, we_i and load_i.
REQ-012 An entry SHALL match source s when valid_i, we_i, src_re_s are all 1, dest_i == src_addr_s, and src_addr_s != 0.
REQ-013 Matching SHALL use youngest-first priority: the lowest matching index i wins.
REQ-014 When the winning entry has load_i=1 and i < LOAD_LAT, stall SHALL be 1 combinationally; otherwise that source contributes no stall.
REQ-015 stall SHALL be the OR of both sources' stall terms, gated by id_valid and by ~flush.
REQ-016 src_data_s SHALL be stage_data[win] when any entry matches, else rf_rdata_s; fwd_hit_s SHALL be 1 exactly when an entry matches.
REQ-017 When pipe_go=0, all entries SHALL hold.
REQ-018 When pipe_go=1, entry i+1 SHALL take entry i for i = 0..NUM_STAGES-2, and the last entry SHALL be discarded.
REQ-019 When pipe_go=1, entry 0 SHALL take {id_valid, id_dest, id_we, id_is_load} if ~stall & ~flush, else a bubble (valid=0).
REQ-020 flush=1 SHALL force the entry-0 write to a bubble even when pipe_go=0; in that case entries 1..N-1 hold.
REQ-021 flush together with stall SHALL yield a bubble with stall=0.
REQ-022 inflight SHALL equal the count of valid entries, registered, updated the same cycle as the entries.
REQ-023 dest=0 entries SHALL be tracked but never match (per REQ-012).
REQ-024 All outputs except inflight SHALL be combinational with zero latency; the entry update latency SHALL be 1 cycle.

Reset
REQ-025 On reset=1 at a clk edge, all valid_i and inflight SHALL clear to 0; dest/we/load are don't-care.
REQ-026 During reset, stall SHALL be 0 and src_data_s SHALL equal rf_rdata_s.
REQ-027 Reset SHALL override pipe_go and flush in the same cycle.

Verification
REQ-028 The bench SHALL check ALU back-to-back: issue add r5 (we=1) with pipe_go; next cycle src1=r5, stage_data[0]=0x11 -> fwd1_hit=1, src1_data=0x11, stall=0.
REQ-029 The bench SHALL check load-use: issue load r7; next cycle src2=r7 -> stall=1 for one cycle, bubble enters entry 0; the following cycle src2_data=stage_data[1].
REQ-030 The bench SHALL check priority: r3 is in entries 0 and 2 with stage_data 0xA/0xC -> src1_data=0xA.
REQ-031 The bench SHALL check r0: entry dest=0 we=1, src1=0, rf_rdata1=0 -> fwd1_hit=0, src1_data=0.
REQ-032 The bench SHALL check flush during load-use stall: flush=1 -> stall=0; next cycle entry 0 invalid, and inflight decrements per shifted entries.
REQ-033 The bench SHALL check reset mid-operation: three valid entries, assert reset -> next cycle inflight=0 and no fwd hits.
